// File: rtl/parity_sched.sv
// parity_sched: round-robin front end sharing one bit-serial parity engine
// between NUM_REQ requesters.
//
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   req_valid    - per-requester word valid
//   req_data     - packed words, requester i at [i*DATA_W +: DATA_W]
//   req_ready    - one-hot accept strobe (combinational, IDLE only)
//   res_valid    - result valid (registered)
//   res_parity   - parity of the accepted word (ODD selects even/odd)
//   res_id       - requester index the result belongs to
//   res_ready    - result consumer ready
//   busy         - high whenever the engine is not IDLE
module parity_sched #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int ODD     = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]    req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic                         res_valid,
  output logic                         res_parity,
  output logic [$clog2(NUM_REQ)-1:0]   res_id,
  input  logic                         res_ready,
  output logic                         busy
);
  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(DATA_W);
  localparam logic ODD_B = 1'(ODD);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t              state_q;
  logic [DATA_W-1:0]   sh_q;
  logic                acc_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [ID_W-1:0]     last_q;
  logic                res_valid_q;
  logic                res_parity_q;
  logic [ID_W-1:0]     res_id_q;

  // Round-robin pick: first valid requester after the last grant.
  logic [ID_W-1:0]     gnt_d;
  logic                found_d;
  logic [ID_W-1:0]     cand;
  int                  pos;

  always_comb begin
    gnt_d   = '0;
    found_d = 1'b0;
    cand    = '0;
    pos     = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      pos  = (int'(last_q) + k) % NUM_REQ;
      cand = ID_W'(pos);
      if (!found_d && req_valid[cand]) begin
        found_d = 1'b1;
        gnt_d   = cand;
      end
    end
  end

  // Gated by rst so no handshake can complete on a reset edge.
  always_comb begin
    req_ready = '0;
    if (state_q == IDLE && found_d && !rst)
      req_ready[gnt_d] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      sh_q         <= '0;
      acc_q        <= 1'b0;
      cnt_q        <= '0;
      last_q       <= ID_W'(NUM_REQ - 1);
      res_valid_q  <= 1'b0;
      res_parity_q <= 1'b0;
      res_id_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|req_ready) begin
            sh_q     <= req_data[gnt_d*DATA_W +: DATA_W];
            acc_q    <= 1'b0;
            cnt_q    <= '0;
            last_q   <= gnt_d;
            res_id_q <= gnt_d;
            state_q  <= SHIFT;
          end
        end
        SHIFT: begin
          acc_q <= acc_q ^ sh_q[0];
          sh_q  <= sh_q >> 1;
          cnt_q <= cnt_q + CNT_W'(1);
          // Final bit folds straight into the result register so the
          // result is visible on the first DONE cycle.
          if (cnt_q == CNT_LAST) begin
            state_q      <= DONE;
            res_valid_q  <= 1'b1;
            res_parity_q <= acc_q ^ sh_q[0] ^ ODD_B;
          end
        end
        DONE: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign res_valid  = res_valid_q;
  assign res_parity = res_parity_q;
  assign res_id     = res_id_q;
  assign busy       = (state_q != IDLE);
endmodule

// File: tb/tb_parity_sched.sv
// Testbench for parity_sched: two instances (even and odd parity) share the
// same stimulus; a cycle-level reference model and result scoreboard check
// grants, busy, result timing, hold under backpressure and parity values.
module tb_parity_sched;
  localparam int NR = 4;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [NR-1:0]   req_valid;
  logic [NR*DW-1:0] req_data;
  logic            res_ready;
  logic [NR-1:0]   rr0, rr1;
  logic            rv0, rv1, rp0, rp1, bz0, bz1;
  logic [1:0]      rid0, rid1;

  always #5 clk = ~clk;

  parity_sched #(.NUM_REQ(NR), .DATA_W(DW), .ODD(0)) dut_even (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(rr0), .res_valid(rv0), .res_parity(rp0), .res_id(rid0),
    .res_ready(res_ready), .busy(bz0));

  parity_sched #(.NUM_REQ(NR), .DATA_W(DW), .ODD(1)) dut_odd (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(rr1), .res_valid(rv1), .res_parity(rp1), .res_id(rid1),
    .res_ready(res_ready), .busy(bz1));

  typedef struct { int id; int par; } exp_t;
  exp_t sb[$];

  int  n_tests = 0;
  int  n_fail  = 0;
  bit  m_busy  = 1'b0;
  int  m_cnt   = 0;
  int  m_last  = NR - 1;
  bit  post_rst = 1'b0;
  bit  hang    = 1'b0;
  logic [NR-1:0] last_acc = '0;

  logic [NR-1:0] pend;
  logic [DW-1:0] pdat [NR];

  task automatic chk(string nm, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Valid requester nearest after 'last' in circular order, or -1.
  function automatic int rr_pick(logic [NR-1:0] v, int last);
    int best = -1;
    int bd   = NR;
    for (int j = 0; j < NR; j++) begin
      int d = (j - last - 1 + 2 * NR) % NR;
      if (v[j] && d < bd) begin
        bd   = d;
        best = j;
      end
    end
    return best;
  endfunction

  // Monitor / reference model, evaluated mid-cycle when everything is stable.
  always @(negedge clk) begin
    logic [NR-1:0] acc;
    logic [NR-1:0] exp_rr;
    logic [DW-1:0] w;
    int   g;
    exp_t e;
    acc = '0;
    if (rst) begin
      m_busy   = 1'b0;
      m_cnt    = 0;
      m_last   = NR - 1;
      post_rst = 1'b1;
      sb.delete();
    end else begin
      if (post_rst) begin
        chk("reset_res_id", int'(rid0), 0);
        chk("reset_res_parity", int'(rp0), 0);
        post_rst = 1'b0;
      end
      chk("wait_timeout", int'(hang), 0);
      chk("busy_even", int'(bz0), int'(m_busy));
      chk("busy_odd", int'(bz1), int'(m_busy));
      chk("res_valid_even", int'(rv0), int'(m_busy && m_cnt == 0));
      chk("res_valid_odd", int'(rv1), int'(m_busy && m_cnt == 0));
      g = m_busy ? -1 : rr_pick(req_valid, m_last);
      exp_rr = '0;
      if (g >= 0) exp_rr[g] = 1'b1;
      chk("req_ready_even", int'(rr0), int'(exp_rr));
      chk("req_ready_odd", int'(rr1), int'(exp_rr));
      if (m_busy && m_cnt == 0) begin
        e = sb[0];
        chk("res_id_even", int'(rid0), e.id);
        chk("res_id_odd", int'(rid1), e.id);
        chk("parity_even", int'(rp0), e.par);
        chk("parity_odd", int'(rp1), e.par ^ 1);
        if (res_ready) begin
          void'(sb.pop_front());
          m_busy = 1'b0;
        end
      end else if (m_busy) begin
        m_cnt--;
      end else if (g >= 0) begin
        w     = req_data[g*DW +: DW];
        e.id  = g;
        e.par = $countones(w) % 2;
        sb.push_back(e);
        m_busy = 1'b1;
        m_cnt  = DW;
        m_last = g;
        acc[g] = 1'b1;
      end
    end
    last_acc = acc;
  end

  task automatic drive();
    req_valid = pend;
    for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = pdat[i];
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    pend = pend & ~last_acc;
    drive();
  endtask

  task automatic req(int i, logic [DW-1:0] d);
    pend[i] = 1'b1;
    pdat[i] = d;
    drive();
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((pend != '0 || m_busy) && n < 400) begin
      step();
      n++;
    end
    if (n >= 400) hang = 1'b1;
  endtask

  task automatic wait_acc(int i);
    int n = 0;
    while (pend[i] && n < 100) begin
      step();
      n++;
    end
    if (n >= 100) hang = 1'b1;
  endtask

  initial begin
    int nacc;
    rst       = 1'b1;
    res_ready = 1'b1;
    pend      = '0;
    for (int i = 0; i < NR; i++) pdat[i] = '0;
    drive();
    step(); step();
    rst = 1'b0;

    // Single request, even parity word
    req(0, 8'hA5);
    wait_idle();
    step();

    // Requester 2, odd-weight word (checked on both parity flavours)
    req(2, 8'h07);
    wait_idle();
    step();

    // All four right after reset: round-robin from requester 0
    rst = 1'b1; step(); rst = 1'b0;
    req(0, 8'h01); req(1, 8'h03); req(2, 8'h07); req(3, 8'hFF);
    wait_idle();
    step();

    // Backpressure with a waiting requester
    req(0, 8'h3C);
    wait_acc(0);
    res_ready = 1'b0;
    req(1, 8'h80);
    repeat (DW + 6) step();
    res_ready = 1'b1;
    wait_idle();
    step();

    // Reset during SHIFT aborts the word; requester 0 wins afterwards
    req(3, 8'h5A);
    wait_acc(3);
    repeat (3) step();
    rst = 1'b1; step(); rst = 1'b0;
    req(1, 8'h0B); req(0, 8'hF1);
    wait_idle();
    step();

    // Two continuous requesters alternate
    nacc = 0;
    for (int c = 0; c < 200 && nacc < 6; c++) begin
      step();
      nacc += $countones(last_acc);
      if (!pend[0]) req(0, DW'($urandom));
      if (!pend[2]) req(2, DW'($urandom));
    end
    pend = '0;
    drive();
    wait_idle();
    step();

    // Randomized traffic, backpressure, drops and occasional resets
    for (int c = 0; c < 3000; c++) begin
      step();
      for (int i = 0; i < NR; i++) begin
        if (!pend[i] && ($urandom % 4) == 0) begin
          pend[i] = 1'b1;
          pdat[i] = DW'($urandom);
        end else if (pend[i] && ($urandom % 40) == 0) begin
          pend[i] = 1'b0;
        end
      end
      res_ready = (($urandom % 3) != 0);
      rst       = (($urandom % 300) == 0);
      drive();
    end

    rst = 1'b0;
    res_ready = 1'b1;
    pend = '0;
    drive();
    wait_idle();
    repeat (3) step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
